// File: rtl/multicycle_controller_pkg.sv
// mc_ctrl_pkg: state encoding, control-field encodings and opcodes shared by controller and datapath
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCA_PC  = 2'b00;
  localparam logic [1:0] SRCA_RS1 = 2'b01;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: controller <-> datapath control bundle
interface multicycle_controller_if;
  logic [31:0] instr;
  logic        zero;
  logic        pc_write;
  logic        ir_write;
  logic        reg_write;
  logic        mem_write;
  logic        instruction_or_data;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_control;
  logic        illegal_instr;
  logic        instr_retired;
  logic [3:0]  state;
  modport master (
    input  instr, zero,
    output pc_write, ir_write, reg_write, mem_write, instruction_or_data, result_src,
           alu_src_a, alu_src_b, alu_control, illegal_instr, instr_retired, state
  );
  modport slave (
    output instr, zero,
    input  pc_write, ir_write, reg_write, mem_write, instruction_or_data, result_src,
           alu_src_a, alu_src_b, alu_control, illegal_instr, instr_retired, state
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps alu_op and instruction funct fields to the ALU operation
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);
  // only R-type (op5=1) with funct7b5 turns funct3=000 into a subtract
  always_comb begin
    alu_control = alu_op == ALUOP_ADD ? ALU_ADD :
                  alu_op == ALUOP_SUB ? ALU_SUB :
                  funct3 == 3'b000    ? ((op5 & funct7b5) ? ALU_SUB : ALU_ADD) :
                  funct3 == 3'b010    ? ALU_SLT :
                  funct3 == 3'b110    ? ALU_OR :
                  funct3 == 3'b111    ? ALU_AND : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM sequencing the multicycle RV32I datapath
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input logic                      clk,
  input logic                      reset_n,
  multicycle_controller_if.master bus
);
  state_t     state, next_state, cur;
  logic [6:0] opcode;
  logic [1:0] alu_op, src_a, src_b, res;
  logic [2:0] alu_ctl;
  logic       iord, irw, rw, mw, pcu, br, ill, ret;
  assign opcode = bus.instr[6:0];
  assign cur    = reset_n ? state : S_FETCH;
  // state register; reset returns to FETCH and abandons any instruction in flight
  always_ff @(posedge clk) state <= reset_n ? next_state : S_FETCH;
  // next-state and per-state control values, everything defaulting to 0
  always_comb begin
    next_state = S_FETCH;
    alu_op     = ALUOP_ADD;
    src_a      = SRCA_PC;
    src_b      = SRCB_RS2;
    res        = RES_ALUOUT;
    iord       = 1'b0;
    irw        = 1'b0;
    rw         = 1'b0;
    mw         = 1'b0;
    pcu        = 1'b0;
    br         = 1'b0;
    ill        = 1'b0;
    ret        = 1'b0;
    case (cur)
      S_FETCH: begin
        irw        = 1'b1;
        src_b      = SRCB_FOUR;
        res        = RES_ALURESULT;
        pcu        = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        src_b      = SRCB_IMM;
        next_state = (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEMADR :
                     opcode == OP_R   ? S_EXECR :
                     opcode == OP_I   ? S_EXECI :
                     opcode == OP_JAL ? S_JAL :
                     opcode == OP_BEQ ? S_BEQ : S_FETCH;
        ill        = next_state == S_FETCH;
      end
      S_MEMADR: begin
        src_a      = SRCA_RS1;
        src_b      = SRCB_IMM;
        next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        iord       = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        res = RES_DATA;
        rw  = 1'b1;
        ret = 1'b1;
      end
      S_MEMWRITE: begin
        iord = 1'b1;
        mw   = 1'b1;
        ret  = 1'b1;
      end
      S_EXECR: begin
        src_a      = SRCA_RS1;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        src_a      = SRCA_RS1;
        src_b      = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        rw  = 1'b1;
        ret = 1'b1;
      end
      S_JAL: begin
        src_b      = SRCB_FOUR;
        pcu        = 1'b1;
        next_state = S_ALUWB;
      end
      S_BEQ: begin
        src_a  = SRCA_RS1;
        alu_op = ALUOP_SUB;
        br     = 1'b1;
        ret    = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end
  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (bus.instr[14:12]),
    .funct7b5    (bus.instr[30]),
    .op5         (opcode[5]),
    .alu_control (alu_ctl)
  );
  assign bus.pc_write            = reset_n & (pcu | (br & bus.zero));
  assign bus.ir_write            = reset_n & irw;
  assign bus.reg_write           = reset_n & rw;
  assign bus.mem_write           = reset_n & mw;
  assign bus.illegal_instr       = reset_n & ill;
  assign bus.instr_retired       = reset_n & ret;
  assign bus.instruction_or_data = iord;
  assign bus.result_src          = res;
  assign bus.alu_src_a           = src_a;
  assign bus.alu_src_b           = src_b;
  assign bus.alu_control         = alu_ctl;
  assign bus.state               = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle vectors checked by a queue-based scoreboard
module tb_multicycle_controller;
  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, rw, mw, iod;
    logic [1:0] res, sa, sb;
    logic [2:0] alu;
    logic       ill, ret;
  } exp_t;
  localparam exp_t E_FETCH = '{st: 4'd0,  pcw: 1, irw: 1, rw: 0, mw: 0, iod: 0, res: 2'd2, sa: 2'd0, sb: 2'd1, alu: 3'd0, ill: 0, ret: 0};
  localparam exp_t E_RST   = '{st: 4'd0,  pcw: 0, irw: 0, rw: 0, mw: 0, iod: 0, res: 2'd2, sa: 2'd0, sb: 2'd1, alu: 3'd0, ill: 0, ret: 0};
  localparam exp_t E_DEC   = '{st: 4'd1,  pcw: 0, irw: 0, rw: 0, mw: 0, iod: 0, res: 2'd0, sa: 2'd0, sb: 2'd2, alu: 3'd0, ill: 0, ret: 0};
  localparam exp_t E_DECX  = '{st: 4'd1,  pcw: 0, irw: 0, rw: 0, mw: 0, iod: 0, res: 2'd0, sa: 2'd0, sb: 2'd2, alu: 3'd0, ill: 1, ret: 0};
  localparam exp_t E_MADR  = '{st: 4'd2,  pcw: 0, irw: 0, rw: 0, mw: 0, iod: 0, res: 2'd0, sa: 2'd1, sb: 2'd2, alu: 3'd0, ill: 0, ret: 0};
  localparam exp_t E_MRD   = '{st: 4'd3,  pcw: 0, irw: 0, rw: 0, mw: 0, iod: 1, res: 2'd0, sa: 2'd0, sb: 2'd0, alu: 3'd0, ill: 0, ret: 0};
  localparam exp_t E_MWB   = '{st: 4'd4,  pcw: 0, irw: 0, rw: 1, mw: 0, iod: 0, res: 2'd1, sa: 2'd0, sb: 2'd0, alu: 3'd0, ill: 0, ret: 1};
  localparam exp_t E_MWR   = '{st: 4'd5,  pcw: 0, irw: 0, rw: 0, mw: 1, iod: 1, res: 2'd0, sa: 2'd0, sb: 2'd0, alu: 3'd0, ill: 0, ret: 1};
  localparam exp_t E_EXR   = '{st: 4'd6,  pcw: 0, irw: 0, rw: 0, mw: 0, iod: 0, res: 2'd0, sa: 2'd1, sb: 2'd0, alu: 3'd0, ill: 0, ret: 0};
  localparam exp_t E_EXI   = '{st: 4'd8,  pcw: 0, irw: 0, rw: 0, mw: 0, iod: 0, res: 2'd0, sa: 2'd1, sb: 2'd2, alu: 3'd0, ill: 0, ret: 0};
  localparam exp_t E_AWB   = '{st: 4'd7,  pcw: 0, irw: 0, rw: 1, mw: 0, iod: 0, res: 2'd0, sa: 2'd0, sb: 2'd0, alu: 3'd0, ill: 0, ret: 1};
  localparam exp_t E_JAL   = '{st: 4'd9,  pcw: 1, irw: 0, rw: 0, mw: 0, iod: 0, res: 2'd0, sa: 2'd0, sb: 2'd1, alu: 3'd0, ill: 0, ret: 0};
  localparam exp_t E_BEQT  = '{st: 4'd10, pcw: 1, irw: 0, rw: 0, mw: 0, iod: 0, res: 2'd0, sa: 2'd1, sb: 2'd0, alu: 3'd1, ill: 0, ret: 1};
  localparam exp_t E_BEQF  = '{st: 4'd10, pcw: 0, irw: 0, rw: 0, mw: 0, iod: 0, res: 2'd0, sa: 2'd1, sb: 2'd0, alu: 3'd1, ill: 0, ret: 1};
  localparam logic [31:0] I_LW   = 32'h00402083;
  localparam logic [31:0] I_SW   = 32'h00102223;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_SLTI = 32'h0050A113;
  localparam logic [31:0] I_ADDI = 32'h40008093;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_ILL  = 32'h0000007F;
  logic   clk = 1'b0;
  logic   reset_n;
  int     passed = 0;
  int     total = 0;
  exp_t   exp_q[$];
  string  name_q[$];
  multicycle_controller_if bus();
  multicycle_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );
  always #5 clk = ~clk;
  // drive one cycle of inputs and queue the response expected for that cycle
  task automatic cyc(input logic rn, input logic [31:0] in, input logic z, input exp_t e, input string nm);
    reset_n   = rn;
    bus.instr = in;
    bus.zero  = z;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask
  // monitor: compare every presented cycle against the oldest queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t  e;
        exp_t  g;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        g  = '{st: bus.state, pcw: bus.pc_write, irw: bus.ir_write, rw: bus.reg_write, mw: bus.mem_write,
               iod: bus.instruction_or_data, res: bus.result_src, sa: bus.alu_src_a, sb: bus.alu_src_b,
               alu: bus.alu_control, ill: bus.illegal_instr, ret: bus.instr_retired};
        total++;
        if (g === e) passed++;
        else $display("FAIL %s: got st=%0d pcw=%b irw=%b rw=%b mw=%b iod=%b res=%0d sa=%0d sb=%0d alu=%0d ill=%b ret=%b, want st=%0d pcw=%b irw=%b rw=%b mw=%b iod=%b res=%0d sa=%0d sb=%0d alu=%0d ill=%b ret=%b",
                      nm, g.st, g.pcw, g.irw, g.rw, g.mw, g.iod, g.res, g.sa, g.sb, g.alu, g.ill, g.ret,
                      e.st, e.pcw, e.irw, e.rw, e.mw, e.iod, e.res, e.sa, e.sb, e.alu, e.ill, e.ret);
      end
    end
  end
  // directed stimulus
  initial begin
    exp_t e;
    reset_n   = 1'b0;
    bus.instr = 32'h0;
    bus.zero  = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, I_LW, 1, E_RST, "reset0");
    cyc(0, I_LW, 1, E_RST, "reset1");
    cyc(1, I_LW, 1, E_FETCH, "lw_fetch");
    cyc(1, I_LW, 1, E_DEC, "lw_decode");
    cyc(1, I_LW, 1, E_MADR, "lw_memadr");
    cyc(1, I_LW, 1, E_MRD, "lw_memread");
    cyc(1, I_LW, 1, E_MWB, "lw_memwb");
    cyc(1, I_SW, 0, E_FETCH, "sw_fetch");
    cyc(1, I_SW, 0, E_DEC, "sw_decode");
    cyc(1, I_SW, 0, E_MADR, "sw_memadr");
    cyc(1, I_SW, 0, E_MWR, "sw_memwrite");
    cyc(1, I_SUB, 1, E_FETCH, "sub_fetch");
    cyc(1, I_SUB, 1, E_DEC, "sub_decode");
    e = E_EXR; e.alu = 3'b001;
    cyc(1, I_SUB, 1, e, "sub_execr");
    cyc(1, I_SUB, 1, E_AWB, "sub_aluwb");
    cyc(1, I_AND, 0, E_FETCH, "and_fetch");
    cyc(1, I_AND, 0, E_DEC, "and_decode");
    e = E_EXR; e.alu = 3'b010;
    cyc(1, I_AND, 0, e, "and_execr");
    cyc(1, I_AND, 0, E_AWB, "and_aluwb");
    cyc(1, I_OR, 0, E_FETCH, "or_fetch");
    cyc(1, I_OR, 0, E_DEC, "or_decode");
    e = E_EXR; e.alu = 3'b011;
    cyc(1, I_OR, 0, e, "or_execr");
    cyc(1, I_OR, 0, E_AWB, "or_aluwb");
    cyc(1, I_SLTI, 0, E_FETCH, "slti_fetch");
    cyc(1, I_SLTI, 0, E_DEC, "slti_decode");
    e = E_EXI; e.alu = 3'b101;
    cyc(1, I_SLTI, 0, e, "slti_execi");
    cyc(1, I_SLTI, 0, E_AWB, "slti_aluwb");
    cyc(1, I_ADDI, 0, E_FETCH, "addi_fetch");
    cyc(1, I_ADDI, 0, E_DEC, "addi_decode");
    cyc(1, I_ADDI, 0, E_EXI, "addi_b30_execi");
    cyc(1, I_ADDI, 0, E_AWB, "addi_aluwb");
    cyc(1, I_BEQ, 1, E_FETCH, "beq_t_fetch");
    cyc(1, I_BEQ, 1, E_DEC, "beq_t_decode");
    cyc(1, I_BEQ, 1, E_BEQT, "beq_taken");
    cyc(1, I_BEQ, 0, E_FETCH, "beq_f_fetch");
    cyc(1, I_BEQ, 0, E_DEC, "beq_f_decode");
    cyc(1, I_BEQ, 0, E_BEQF, "beq_not_taken");
    cyc(1, I_JAL, 0, E_FETCH, "jal_fetch");
    cyc(1, I_JAL, 0, E_DEC, "jal_decode");
    cyc(1, I_JAL, 0, E_JAL, "jal_jal");
    cyc(1, I_JAL, 0, E_AWB, "jal_aluwb");
    cyc(1, I_ILL, 1, E_FETCH, "ill_fetch");
    cyc(1, I_ILL, 1, E_DECX, "ill_decode");
    cyc(1, I_LW, 0, E_FETCH, "mid_fetch");
    cyc(1, I_LW, 0, E_DEC, "mid_decode");
    cyc(1, I_LW, 0, E_MADR, "mid_memadr");
    cyc(1, I_LW, 0, E_MRD, "mid_memread");
    e = E_RST; e.st = 4'd4;
    cyc(0, I_LW, 0, e, "mid_reset_memwb");
    cyc(1, I_LW, 0, E_FETCH, "mid_after_reset");
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  // watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RV32I core. It decodes the registered instruction word and the ALU zero flag from the datapath, then sequences the Moore-style control outputs that drive the datapath's write enables, operand muxes, result mux and ALU operation. Each instruction takes 3–5 cycles. The block sits beside the datapath: its outputs connect one-to-one to the datapath's control inputs, and the datapath's instruction-register output feeds back into `instr`.

## Interface
- Parameters: none. Control encodings are constants from `mc_ctrl_pkg`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `instr` in 32: current instruction register contents (opcode [6:0], funct3 [14:12], funct7b5 [30]).
- `zero` in 1: ALU result == 0 this cycle.
- `pc_write` out 1: PC load enable; equals `pc_update | (branch & zero)`.
- `ir_write` out 1: instruction register load.
- `reg_write` out 1: register-file write.
- `mem_write` out 1: data memory write.
- `instruction_or_data` out 1: memory address select; 0 = pc, 1 = result.
- `result_src` out 2: 00 alu_out, 01 data, 10 alu_result.
- `alu_src_a` out 2: 00 pc, 01 rs1.
- `alu_src_b` out 2: 00 rs2, 01 constant 4, 10 immediate.
- `alu_control` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `illegal_instr` out 1: one-cycle pulse in DECODE for an unsupported opcode.
- `instr_retired` out 1: one-cycle pulse in the last state of each instruction.
- `state` out 4: current state, for debug.

## Operation
- States, 4-bit: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10. Encodings 11–15 go to FETCH on the next edge.
- FETCH: `instruction_or_data`=0, `ir_write`=1, `alu_src_a`=00, `alu_src_b`=01, add, `result_src`=10, `pc_update`=1. Next state is DECODE.
- DECODE: `alu_src_a`=00, `alu_src_b`=10, add. Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - anything else → FETCH, with `illegal_instr`=1
- MEMADR: `alu_src_a`=01, `alu_src_b`=10, add. Goes to MEMREAD if opcode[5]=0, otherwise MEMWRITE.
- MEMREAD: `result_src`=00, `instruction_or_data`=1. Next state is MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1, retire. Next state is FETCH.
- MEMWRITE: `result_src`=00, `instruction_or_data`=1, `mem_write`=1, retire. Next state is FETCH.
- EXECR: `alu_src_a`=01, `alu_src_b`=00, ALU op from funct. Next state is ALUWB.
- EXECI: `alu_src_a`=01, `alu_src_b`=10, ALU op from funct. Next state is ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, retire. Next state is FETCH.
- JAL: `alu_src_a`=00, `alu_src_b`=01, `result_src`=00, `pc_update`=1. Next state is ALUWB.
- BEQ: `alu_src_a`=01, `alu_src_b`=00, sub, `result_src`=00, `branch`=1, retire. Next state is FETCH.
- ALU decoder, with `alu_op` taken from the state (00 add, 01 sub, 10 funct):
  - funct3 000 → sub when opcode[5] & funct7b5, otherwise add
  - funct3 010 → slt
  - funct3 110 → or
  - funct3 111 → and
  - any other funct3 → add
- Any output not listed for a state is 0.

## Timing
- `state` is registered. All outputs are combinational from `state`, `instr` and `zero`; there are no registered outputs.
- Instruction latency in cycles, counted from FETCH to the next FETCH: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2.
- While `reset_n`=0 at a rising edge, `state` is set to FETCH.
- During reset (`reset_n`=0), all enable outputs are forced to 0, combinationally gated: `pc_write`, `ir_write`, `reg_write`, `mem_write`, `illegal_instr`, `instr_retired`. Mux selects show their FETCH values.
- Reset asserted mid-instruction abandons that instruction and suppresses any write in that cycle. The first cycle after release is FETCH.
- `zero` is sampled only in BEQ; it is ignored in every other state.
- No output depends on `instr` outside the DECODE, MEMADR, EXECR and EXECI states.

## Structure
- `mc_ctrl_pkg` holds:
  - the state enum
  - `ALU_ADD/SUB/AND/OR/SLT`
  - `SRCA_*`, `SRCB_*`, `RES_*`
  - opcode constants `OP_LOAD`, `OP_STORE`, `OP_R`, `OP_I`, `OP_JAL`, `OP_BEQ`
- The datapath imports the same package.
- One sub-module, `alu_decoder`: purely combinational (`alu_op`, funct3, funct7b5, opcode[5] → `alu_control`).

## Test plan
- Reset and lw: hold `reset_n`=0 for 2 cycles, release, instr=0x00402083 (lw x1,4(x0)).
  - Expect states 0,1,2,3,4,0.
  - `reg_write`=1 only in state 4, with `result_src`=01.
  - `instr_retired` pulses once.
- sw, instr=0x00102223: states 0,1,2,5,0. `mem_write`=1 only in state 5, with `instruction_or_data`=1.
- R-type:
  - instr=0x402081B3 (sub): EXECR shows `alu_control`=001, `alu_src_b`=00.
  - instr=0x0020F1B3 (and): EXECR shows `alu_control`=010.
- beq, instr=0x00208463:
  - `zero`=1: `pc_write`=1 in BEQ.
  - `zero`=0: `pc_write`=0 in BEQ.
  - Both cases: 3 cycles total.
- jal and illegal:
  - jal (0x008000EF): states 0,1,9,7,0, with `pc_write`=1 in state 9.
  - instr=0x0000007F: `illegal_instr`=1 in DECODE, back to FETCH, no write enables asserted.
- Reset mid-op: drop `reset_n` while in MEMWB. Expect `reg_write`=0 that cycle and `state`=0 after the next edge.
